matrix_sequencer: RTL and testbench

Sequences the MAX7219 8x8 LED-matrix driver: after reset it issues the controller init words, then streams the eight row words from an internal framebuffer to the 16-bit shift-out serializer, one word at a time over a valid/ready/done handshake. It sits between the design's pixel source and the serializer, replacing hard-coded per-word sequencing in the top level. Rows written by the pixel source are marked dirty and re-sent. A periodic full refresh re-sends init plus all rows to recover from display glitches.

---
 rtl/matrix_pkg.sv | 32 +++
 rtl/matrix_framebuf.sv | 38 +++
 rtl/matrix_sequencer.sv | 172 +++++++++++++++++
 tb/tb_matrix_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, state type and word builder for the MAX7219 matrix sequencer.
// MATRIX_SEQ_DISPTEST_EN selects the 6-word init sequence with a display-test flash.
package matrix_pkg;

    localparam logic [3:0] REG_NOOP      = 4'h0;
    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIMIT = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_DISPTEST  = 4'hF;

`ifdef MATRIX_SEQ_DISPTEST_EN
    localparam int INIT_WORDS = 6;
`else
    localparam int INIT_WORDS = 5;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROWS,
        S_SEND,
        S_WAIT,
        S_HOLD
    } state_t;

    function automatic logic [15:0] make_word(input logic [3:0] addr, input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction

endpackage

// File: rtl/matrix_framebuf.sv
// 8x8 pixel framebuffer with per-row dirty bits.
// A write always marks its row dirty; a write in the same cycle as a clear keeps the row dirty.
module matrix_framebuf (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [2:0]      waddr,
    input  logic [7:0]      wdata,
    input  logic            set_all,
    input  logic            clr,
    input  logic [2:0]      clr_addr,
    output logic [7:0][7:0] rows,
    output logic [7:0]      dirty
);

    logic [7:0] dirty_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dirty_next = dirty;
        if (set_all) dirty_next = '1;
        if (clr)     dirty_next[clr_addr] = 1'b0;
        if (we)      dirty_next[waddr] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignment only, so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the pixel store is reset because a blank display is the defined start state.
            rows  <= '0;
            dirty <= '0;
        end else begin
            if (we) rows[waddr] <= wdata;
            dirty <= dirty_next;
        end
    end

endmodule

// File: rtl/matrix_sequencer.sv
// MAX7219 sequencer: init words, then dirty rows, then periodic full refresh, over valid/ready/done.
// Define MATRIX_SEQ_DISPTEST_EN to flash display-test (all LEDs) once per init.
module matrix_sequencer
    import matrix_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 600000,
    parameter int unsigned SCAN_LIMIT     = 7,
    parameter int unsigned INTENSITY      = 8
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        row_we_in,
    input  logic [2:0]  row_addr_in,
    input  logic [7:0]  row_data_in,
    output logic [15:0] word_out,
    output logic        word_valid_out,
    input  logic        word_ready_in,
    input  logic        word_done_in,
    output logic        busy_out,
    output logic        init_done_out
);

    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    state_t           state, state_next;
    logic [3:0]       idx, idx_next;        // init word k, or lowest row still to scan (8 = done)
    logic             in_init, in_init_next;
    logic             init_done, init_done_next;
    logic [15:0]      word, word_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic [7:0][7:0]  rows;
    logic [7:0]       dirty;
    logic             fb_set_all, fb_clr;
    logic             found;
    logic [2:0]       found_row;
    logic [15:0]      init_word;

    matrix_framebuf u_framebuf (
        .clk      (clk_in),
        .rst      (reset_in),
        .we       (row_we_in),
        .waddr    (row_addr_in),
        .wdata    (row_data_in),
        .set_all  (fb_set_all),
        .clr      (fb_clr),
        .clr_addr (found_row),
        .rows     (rows),
        .dirty    (dirty)
    );

    // Lowest dirty row at or above idx; descending loop so the lowest match is written last.
    always_comb begin
        found     = 1'b0;
        found_row = '0;
        for (int r = 7; r >= 0; r--) begin
            if (dirty[r] && (4'(r) >= idx)) begin
                found     = 1'b1;
                found_row = 3'(r);
            end
        end
    end

    always_comb begin
        init_word = make_word(REG_NOOP, 8'h00);
        case (idx)
`ifdef MATRIX_SEQ_DISPTEST_EN
            4'd0: init_word = make_word(REG_SHUTDOWN,  8'h01);
            4'd1: init_word = make_word(REG_DISPTEST,  8'h01);
            4'd2: init_word = make_word(REG_DISPTEST,  8'h00);
            4'd3: init_word = make_word(REG_DECODE,    8'h00);
            4'd4: init_word = make_word(REG_SCANLIMIT, 8'(SCAN_LIMIT));
            4'd5: init_word = make_word(REG_INTENSITY, 8'(INTENSITY));
`else
            4'd0: init_word = make_word(REG_SHUTDOWN,  8'h01);
            4'd1: init_word = make_word(REG_DISPTEST,  8'h00);
            4'd2: init_word = make_word(REG_DECODE,    8'h00);
            4'd3: init_word = make_word(REG_SCANLIMIT, 8'(SCAN_LIMIT));
            4'd4: init_word = make_word(REG_INTENSITY, 8'(INTENSITY));
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_next     = state;
        idx_next       = idx;
        in_init_next   = in_init;
        init_done_next = init_done;
        word_next      = word;
        cnt_next       = '0;
        fb_set_all     = 1'b0;
        fb_clr         = 1'b0;
        case (state)
            S_IDLE: begin
                idx_next     = '0;
                in_init_next = 1'b1;
                fb_set_all   = 1'b1;
                state_next   = S_INIT;
            end
            S_INIT: begin
                word_next  = init_word;
                state_next = S_SEND;
            end
            S_ROWS: begin
                if (found) begin
                    word_next  = make_word(REG_DIGIT0 + {1'b0, found_row}, rows[found_row]);
                    fb_clr     = 1'b1;
                    idx_next   = {1'b0, found_row};
                    state_next = S_SEND;
                end else begin
                    state_next = S_HOLD;
                end
            end
            S_SEND: begin
                if (word_ready_in) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (word_done_in) begin
                    idx_next = idx + 4'd1;
                    if (!in_init) begin
                        state_next = S_ROWS;
                    end else if (idx == 4'(INIT_WORDS - 1)) begin
                        idx_next       = '0;
                        in_init_next   = 1'b0;
                        init_done_next = 1'b1;
                        state_next     = S_ROWS;
                    end else begin
                        state_next = S_INIT;
                    end
                end
            end
            S_HOLD: begin
                // A pending row always beats refresh expiry.
                if (|dirty) begin
                    idx_next   = '0;
                    state_next = S_ROWS;
                end else if (cnt == CNT_LAST) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state     <= S_IDLE;
            idx       <= '0;
            in_init   <= 1'b1;
            init_done <= 1'b0;
            word      <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            in_init   <= in_init_next;
            init_done <= init_done_next;
            word      <= word_next;
            cnt       <= cnt_next;
        end
    end

    assign word_out       = word;
    assign word_valid_out = (state == S_SEND);
    assign busy_out       = !((state == S_IDLE) || (state == S_HOLD));
    assign init_done_out  = init_done;

endmodule

// File: tb/tb_matrix_sequencer.sv
// Self-checking bench for matrix_sequencer: serializer model plus a word-list reference model.
`timescale 1ns/1ps
module tb_matrix_sequencer;

    localparam int REFRESH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [2:0]  addr = '0;
    logic [7:0]  data = '0;
    logic [15:0] word;
    logic        valid;
    logic        ready = 1'b0;
    logic        done = 1'b0;
    logic        busy;
    logic        init_done;

    always #5 clk = ~clk;

    matrix_sequencer #(
        .REFRESH_CYCLES (REFRESH),
        .SCAN_LIMIT     (7),
        .INTENSITY      (8)
    ) dut (
        .clk_in         (clk),
        .reset_in       (rst),
        .row_we_in      (we),
        .row_addr_in    (addr),
        .row_data_in    (data),
        .word_out       (word),
        .word_valid_out (valid),
        .word_ready_in  (ready),
        .word_done_in   (done),
        .busy_out       (busy),
        .init_done_out  (init_done)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  fb [8];
    logic [15:0] xfer_q [$];
    logic [15:0] exp_q [$];
    bit          hold_off = 1'b0;
    bit          rand_ready = 1'b0;
    int          done_cnt = 0;

    logic [2:0]  r, r2;
    logic [7:0]  d, d2;
    logic [15:0] held;

    // Serializer model: chooses ready for the coming edge, logs transfers, pulses done 4 clocks later.
    always @(negedge clk) begin
        done = 1'b0;
        if (rst) begin
            done_cnt = 0;
            ready    = 1'b0;
        end else begin
            if (done_cnt != 0) begin
                done_cnt--;
                if (done_cnt == 0) done = 1'b1;
            end
            ready = rand_ready ? 1'($urandom_range(0, 1)) : !hold_off;
            if (valid && ready) begin
                xfer_q.push_back(word);
                done_cnt = 4;
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] row_word(input logic [2:0] row, input logic [7:0] val);
        return {4'h0, 4'(row) + 4'd1, val};
    endfunction

    task automatic push_full();
        exp_q.push_back(16'h0C01);
`ifdef MATRIX_SEQ_DISPTEST_EN
        exp_q.push_back(16'h0F01);
`endif
        exp_q.push_back(16'h0F00);
        exp_q.push_back(16'h0900);
        exp_q.push_back(16'h0B07);
        exp_q.push_back(16'h0A08);
        for (int i = 0; i < 8; i++) exp_q.push_back(row_word(3'(i), fb[i]));
    endtask

    task automatic compare_log(input string tag);
        check($sformatf("%s count", tag), 16'(xfer_q.size()), 16'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < xfer_q.size(); i++)
            check($sformatf("%s word %0d", tag, i), xfer_q[i], exp_q[i]);
        xfer_q.delete();
        exp_q.delete();
    endtask

    // Returns on the third consecutive idle negedge of HOLD (refresh count 2).
    task automatic wait_quiet(input string tag);
        int run = 0;
        int n = 0;
        while (run < 3 && n < 2000) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0) run++;
            else run = 0;
        end
        checks++;
        assert (run == 3) else begin
            errors++;
            $error("FAIL %s: observed no HOLD within %0d cycles, expected HOLD", tag, n);
        end
    endtask

    task automatic wait_in_wait(input string tag);
        int n = 0;
        while (!(xfer_q.size() > 0 && valid === 1'b0 && busy === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 100) else begin
            errors++;
            $error("FAIL %s: observed no WAIT within %0d cycles, expected WAIT", tag, n);
        end
    endtask

    task automatic write_row(input logic [2:0] row, input logic [7:0] val);
        we    = 1'b1;
        addr  = row;
        data  = val;
        fb[row] = val;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic bringup(input string tag);
        rst = 1'b0;
        @(negedge clk);
        check({tag, " valid+1"}, 16'(valid), 16'h0);
        @(negedge clk);
        check({tag, " valid+2"}, 16'(valid), 16'h1);
        check({tag, " first word"}, word, 16'h0C01);
        push_full();
        wait_quiet(tag);
        compare_log(tag);
        check({tag, " busy"}, 16'(busy), 16'h0);
        check({tag, " init_done"}, 16'(init_done), 16'h1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) fb[i] = 8'h00;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset word", word, 16'h0);
        check("reset valid", 16'(valid), 16'h0);
        check("reset busy", 16'(busy), 16'h0);
        check("reset init_done", 16'(init_done), 16'h0);

        bringup("bringup");

        // Dirty resend: valid 3 clocks after a write in HOLD, exactly one word
        for (int k = 0; k < 3; k++) begin
            r = (k == 0) ? 3'd3 : 3'($urandom_range(0, 7));
            d = (k == 0) ? 8'hA5 : 8'($urandom);
            we = 1'b1; addr = r; data = d; fb[r] = d;
            @(negedge clk);
            we = 1'b0;
            check("resend valid+1", 16'(valid), 16'h0);
            @(negedge clk);
            check("resend valid+2", 16'(valid), 16'h0);
            @(negedge clk);
            check("resend valid+3", 16'(valid), 16'h1);
            check("resend word", word, row_word(r, d));
            exp_q.push_back(row_word(r, d));
            wait_quiet("resend");
            compare_log("resend");
        end

        // Backpressure: valid held and word stable for 10 stalled clocks, then one transfer
        hold_off = 1'b1;
        r = 3'($urandom_range(0, 7));
        d = 8'($urandom);
        write_row(r, d);
        for (int n = 0; n < 20 && valid !== 1'b1; n++) @(negedge clk);
        check("stall valid seen", 16'(valid), 16'h1);
        held = word;
        repeat (10) begin
            @(negedge clk);
            check("stall valid", 16'(valid), 16'h1);
            check("stall word", word, held);
        end
        check("stall no transfer", 16'(xfer_q.size()), 16'h0);
        hold_off = 1'b0;
        exp_q.push_back(row_word(r, d));
        wait_quiet("stall");
        compare_log("stall");

        // Write while the row's word sits in WAIT: old word sent, then resent with new data
        for (int k = 0; k < 2; k++) begin
            r  = (k == 0) ? 3'd2 : 3'($urandom_range(0, 7));
            d  = (k == 0) ? 8'h3C : 8'($urandom);
            d2 = (k == 0) ? 8'hFF : 8'($urandom);
            write_row(r, d);
            wait_in_wait("wait write");
            write_row(r, d2);
            exp_q.push_back(row_word(r, d));
            exp_q.push_back(row_word(r, d2));
            wait_quiet("wait write");
            compare_log("wait write");
        end

        // Write on the same edge the row is captured: capture keeps old data, row stays dirty
        r  = 3'($urandom_range(0, 7));
        d  = 8'($urandom);
        d2 = ~d;
        write_row(r, d);
        @(negedge clk);
        write_row(r, d2);
        exp_q.push_back(row_word(r, d));
        exp_q.push_back(row_word(r, d2));
        wait_quiet("capture race");
        compare_log("capture race");

        // Random backpressure, two back-to-back writes: rows go out once each, ascending
        rand_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            r  = 3'($urandom_range(0, 7));
            r2 = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            d2 = 8'($urandom);
            write_row(r, d);
            write_row(r2, d2);
            if (r == r2) begin
                exp_q.push_back(row_word(r, fb[r]));
            end else begin
                exp_q.push_back(row_word((r < r2) ? r : r2, fb[(r < r2) ? r : r2]));
                exp_q.push_back(row_word((r < r2) ? r2 : r, fb[(r < r2) ? r2 : r]));
            end
            wait_quiet("random ready");
            compare_log("random ready");
        end
        rand_ready = 1'b0;

        // Refresh: idle through HOLD, IDLE on the 16th clock, then full init plus rows
        for (int i = 3; i <= 15; i++) begin
            @(negedge clk);
            check($sformatf("refresh hold %0d busy", i), 16'(busy), 16'h0);
        end
        @(negedge clk);
        check("refresh idle busy", 16'(busy), 16'h0);
        check("refresh idle valid", 16'(valid), 16'h0);
        @(negedge clk);
        check("refresh init busy", 16'(busy), 16'h1);
        @(negedge clk);
        check("refresh valid", 16'(valid), 16'h1);
        check("refresh first word", word, 16'h0C01);
        push_full();
        wait_quiet("refresh");
        compare_log("refresh");
        check("refresh init_done", 16'(init_done), 16'h1);

        // Reset mid-word during WAIT
        r = 3'($urandom_range(0, 7));
        d = 8'($urandom);
        write_row(r, d);
        wait_in_wait("mid reset");
        rst = 1'b1;
        #1;
        check("mid reset word", word, 16'h0);
        check("mid reset valid", 16'(valid), 16'h0);
        check("mid reset busy", 16'(busy), 16'h0);
        check("mid reset init_done", 16'(init_done), 16'h0);
        repeat (2) begin
            @(negedge clk);
            check("held reset word", word, 16'h0);
            check("held reset valid", 16'(valid), 16'h0);
        end
        xfer_q.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) fb[i] = 8'h00;
        bringup("rebringup");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish by 2 ms, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
